// File: rtl/comparator_4bit_dataflow.sv
// -----------------------------------------------------------------------------
// comparator_4bit_dataflow
//
// Registered 4-bit unsigned magnitude comparator with saturating result counters.
// The compare itself is pure dataflow: one XNOR per bit position, and the
// "greater than" term is resolved from the MSB downward. A strobed sample loads
// the one-hot result into flops, and the counter for that result is bumped.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous, active-high reset
//   en                  sample strobe; high = compare and register this cycle
//   a3..a0              operand A, a3 is the MSB (unsigned 0..15)
//   b3..b0              operand B, b3 is the MSB (unsigned 0..15)
//   x                   registered A > B
//   y                   registered A == B
//   z                   registered A < B
//   valid               high once x/y/z hold a sampled result
//   gt_cnt/eq_cnt/lt_cnt  saturating (255) counts of sampled GT/EQ/LT results
// -----------------------------------------------------------------------------
module comparator_4bit_dataflow (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a3,
   input  logic       a2,
   input  logic       a1,
   input  logic       a0,
   input  logic       b3,
   input  logic       b2,
   input  logic       b1,
   input  logic       b0,
   output logic       x,
   output logic       y,
   output logic       z,
   output logic       valid,
   output logic [7:0] gt_cnt,
   output logic [7:0] eq_cnt,
   output logic [7:0] lt_cnt
);

   // Per-bit equality: ei is high when ai and bi agree.
   logic e3, e2, e1, e0;
   logic gt, eq, lt;

   assign e3 = ~(a3 ^ b3);
   assign e2 = ~(a2 ^ b2);
   assign e1 = ~(a1 ^ b1);
   assign e0 = ~(a0 ^ b0);

   assign eq = e3 & e2 & e1 & e0;

   // A wins at the highest bit where the operands differ; every term is gated
   // by equality of all more-significant bits.
   assign gt = (a3 & ~b3)
             | (e3 & a2 & ~b2)
             | (e3 & e2 & a1 & ~b1)
             | (e3 & e2 & e1 & a0 & ~b0);

   // Exactly one of gt/eq/lt holds, so lt needs no magnitude logic of its own.
   assign lt = ~gt & ~eq;

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x      <= 1'b0;
         y      <= 1'b0;
         z      <= 1'b0;
         valid  <= 1'b0;
         gt_cnt <= 8'd0;
         eq_cnt <= 8'd0;
         lt_cnt <= 8'd0;
      end else if (en) begin
         x     <= gt;
         y     <= eq;
         z     <= lt;
         valid <= 1'b1;
         // Counters stop at all-ones instead of wrapping back to zero.
         if (gt && (gt_cnt != 8'hff)) gt_cnt <= gt_cnt + 8'd1;
         if (eq && (eq_cnt != 8'hff)) eq_cnt <= eq_cnt + 8'd1;
         if (lt && (lt_cnt != 8'hff)) lt_cnt <= lt_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_comparator_4bit_dataflow.sv
// -----------------------------------------------------------------------------
// tb_comparator_4bit_dataflow
//
// Directed bench for comparator_4bit_dataflow. A behavioural model (integer
// compare, saturating integer counters) predicts the registered outputs; each
// prediction is queued when the stimulus is driven and popped after the next
// rising edge to be compared with the DUT.
// -----------------------------------------------------------------------------
module tb_comparator_4bit_dataflow;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [3:0] a   = 4'd0;
   logic [3:0] b   = 4'd0;
   logic       x, y, z, valid;
   logic [7:0] gt_cnt, eq_cnt, lt_cnt;

   int errors = 0;
   int checks = 0;

   // Model state.
   logic m_x = 1'b0, m_y = 1'b0, m_z = 1'b0, m_valid = 1'b0;
   int   m_gt = 0, m_eq = 0, m_lt = 0;

   logic [27:0] sb[$];

   always #5 clk = ~clk;

   comparator_4bit_dataflow dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .a3     (a[3]),
      .a2     (a[2]),
      .a1     (a[1]),
      .a0     (a[0]),
      .b3     (b[3]),
      .b2     (b[2]),
      .b1     (b[1]),
      .b0     (b[0]),
      .x      (x),
      .y      (y),
      .z      (z),
      .valid  (valid),
      .gt_cnt (gt_cnt),
      .eq_cnt (eq_cnt),
      .lt_cnt (lt_cnt)
   );

   // Packed view {x,y,z,valid,gt_cnt,eq_cnt,lt_cnt}.
   function automatic logic [27:0] obs();
      return {x, y, z, valid, gt_cnt, eq_cnt, lt_cnt};
   endfunction

   function automatic logic [27:0] model_vec();
      return {m_x, m_y, m_z, m_valid, m_gt[7:0], m_eq[7:0], m_lt[7:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic model_clear();
      m_x = 1'b0; m_y = 1'b0; m_z = 1'b0; m_valid = 1'b0;
      m_gt = 0; m_eq = 0; m_lt = 0;
   endtask

   // Drive one cycle of stimulus at the falling edge, queue the prediction,
   // then compare after the following rising edge.
   task automatic step(input string tag, input logic e, input logic [3:0] av, input logic [3:0] bv);
      logic [27:0] want;
      @(negedge clk);
      en = e; a = av; b = bv;
      if (e) begin
         m_x = (av > bv);
         m_y = (av == bv);
         m_z = (av < bv);
         m_valid = 1'b1;
         if (av > bv  && m_gt < 255) m_gt++;
         if (av == bv && m_eq < 255) m_eq++;
         if (av < bv  && m_lt < 255) m_lt++;
      end
      sb.push_back(model_vec());
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         want = sb.pop_front();
         check(tag, {4'h0, obs()}, {4'h0, want});
      end
   endtask

   // Asynchronous reset pulse placed between clock edges; en is held high
   // across an edge while rst is asserted to show it is ignored.
   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check({tag, "_async"}, {4'h0, obs()}, 32'h0);
      model_clear();
      en = 1'b1; a = 4'd9; b = 4'd3;
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {4'h0, obs()}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
   endtask

   initial begin
      // Power-up reset held across two edges.
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_state", {4'h0, obs()}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Single equal sample of zeros.
      step("eq_zero", 1'b1, 4'b0000, 4'b0000);
      check("eq_zero_xyzv", {28'h0, x, y, z, valid}, 32'b0101);
      check("eq_zero_cnt", {24'h0, eq_cnt}, 32'd1);

      // Mixed sequence from a clean start.
      pulse_reset("rst_seq");
      step("seq0", 1'b1, 4'b0101, 4'b0011);
      check("seq0_xyz", {29'h0, x, y, z}, 32'b100);
      step("seq1", 1'b1, 4'b0010, 4'b1010);
      check("seq1_xyz", {29'h0, x, y, z}, 32'b001);
      step("seq2", 1'b1, 4'b1100, 4'b1010);
      check("seq2_xyz", {29'h0, x, y, z}, 32'b100);
      step("seq3", 1'b1, 4'b0111, 4'b0111);
      check("seq3_xyz", {29'h0, x, y, z}, 32'b010);
      check("seq_cnts", {8'h0, gt_cnt, eq_cnt, lt_cnt}, {8'h0, 8'd2, 8'd1, 8'd1});

      // Hold with en low while the operands swap.
      pulse_reset("rst_hold");
      step("hold_sample", 1'b1, 4'b1111, 4'b0000);
      for (int i = 0; i < 3; i++) step("hold_idle", 1'b0, 4'b0000, 4'b1111);
      check("hold_xyz", {29'h0, x, y, z}, 32'b100);
      check("hold_cnts", {8'h0, gt_cnt, eq_cnt, lt_cnt}, {8'h0, 8'd1, 8'd0, 8'd0});

      // Saturation of the equal counter.
      pulse_reset("rst_sat");
      for (int i = 0; i < 300; i++) step("sat", 1'b1, 4'b1000, 4'b1000);
      check("sat_eq_cnt", {24'h0, eq_cnt}, 32'd255);
      check("sat_other", {16'h0, gt_cnt, lt_cnt}, 32'h0);
      check("sat_y", {31'h0, y}, 32'd1);

      // Mid-operation asynchronous reset, then a fresh first sample.
      pulse_reset("rst_pre_mid");
      step("mid0", 1'b1, 4'd7, 4'd2);
      step("mid1", 1'b1, 4'd4, 4'd4);
      step("mid2", 1'b1, 4'd1, 4'd14);
      pulse_reset("rst_mid");
      step("post_rst", 1'b1, 4'b0001, 4'b0010);
      check("post_rst_z", {31'h0, z}, 32'd1);
      check("post_rst_lt", {24'h0, lt_cnt}, 32'd1);

      // Every operand pair.
      pulse_reset("rst_exh");
      for (int i = 0; i < 256; i++) begin
         logic [7:0] ab;
         ab = i[7:0];
         step("exh", 1'b1, ab[7:4], ab[3:0]);
      end
      check("exh_cnts", {8'h0, gt_cnt, eq_cnt, lt_cnt}, {8'h0, 8'd120, 8'd16, 8'd120});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
